// File: rtl/regfile_sb.sv
// Multi-ported register file with a per-register pending (busy) scoreboard.
// Optional same-cycle write forwarding and optional hardwired-zero register 0.
module regfile_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned NUM_RD   = 6,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_R0  = 0,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*AW-1:0]       rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR*AW-1:0]       wr_addr,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    input  logic                       alloc_en,
    input  logic [AW-1:0]              alloc_addr,
    output logic                       alloc_ok,
    output logic [NUM_REGS-1:0]        busy_vec
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   wr_val [NUM_REGS];
    logic                zero_alloc;

    // Resolve writes per register; scanning ports upward lets the highest index win.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            wr_hit[r] = 1'b0;
            wr_val[r] = '0;
            for (int unsigned p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] == AW'(r) && !(ZERO_R0 != 0 && r == 0)) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign zero_alloc = (ZERO_R0 != 0) && (alloc_addr == '0);
    assign alloc_ok   = alloc_en && (!busy_q[alloc_addr] || zero_alloc);

    // Alloc is applied after the write clear so an accepted alloc keeps the register pending.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
            if (wr_hit[r]) begin
                busy_d[r] = 1'b0;
            end
        end
        if (alloc_ok && !zero_alloc) begin
            busy_d[alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    always_comb begin
        logic [AW-1:0] a;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            a = rd_addr[i*AW +: AW];
            if (BYPASS != 0 && wr_hit[a]) begin
                rd_data[i*DATA_W +: DATA_W] = wr_val[a];
                rd_busy[i]                  = 1'b0;
            end else begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[a];
                rd_busy[i]                  = busy_q[a];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default build, a no-forwarding build and a
// zero-register build share one stimulus stream.
module tb_regfile_sb;

    logic        clk;
    logic        rst_n;
    logic [17:0] rd_addr;
    logic [1:0]  wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [2:0]  alloc_addr;

    logic [95:0] rd_data,  rd_data_nb,  rd_data_z;
    logic [5:0]  rd_busy,  rd_busy_nb,  rd_busy_z;
    logic        alloc_ok, alloc_ok_nb, alloc_ok_z;
    logic [7:0]  busy_vec, busy_vec_nb, busy_vec_z;

    int checks = 0;
    int errors = 0;

    regfile_sb dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .alloc_ok(alloc_ok), .busy_vec(busy_vec)
    );

    regfile_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_nb), .busy_vec(busy_vec_nb)
    );

    regfile_sb #(.ZERO_R0(1)) dut_z (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .alloc_ok(alloc_ok_z), .busy_vec(busy_vec_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdd(input int i);
        return 32'(rd_data[i*16 +: 16]);
    endfunction
    function automatic logic [31:0] rdnb(input int i);
        return 32'(rd_data_nb[i*16 +: 16]);
    endfunction
    function automatic logic [31:0] rdz(input int i);
        return 32'(rd_data_z[i*16 +: 16]);
    endfunction

    task automatic idle();
        wr_en    = '0;
        alloc_en = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input int a);
        rd_addr[i*3 +: 3] = 3'(a);
    endtask

    task automatic wr(input int p, input int a, input logic [15:0] d);
        wr_en[p]           = 1'b1;
        wr_addr[p*3 +: 3]  = 3'(a);
        wr_data[p*16 +: 16] = d;
    endtask

    task automatic alloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = 3'(a);
    endtask

    initial begin
        rst_n = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
        idle();
        #1;
        // Reset state and combinational outputs while held in reset
        check("rst_busy_vec", 32'(busy_vec), 32'h0);
        check("rst_rd0", rdd(0), 32'h0);
        alloc(5);
        #1 check("rst_alloc_ok", 32'(alloc_ok), 32'h1);
        wr(0, 1, 16'h1234); set_rd(0, 1);
        #1;
        check("rst_fwd", rdd(0), 32'h1234);
        check("rst_nofwd", rdnb(0), 32'h0);
        check("rst_rd_busy", 32'(rd_busy), 32'h0);
        tick(); tick();
        check("rst_hold_busy", 32'(busy_vec), 32'h0);
        idle();
        #1 rst_n = 1'b1;
        #1 check("rst_no_write", rdd(0), 32'h0);

        // Single write, broadcast read
        tick();
        wr(0, 3, 16'hBEEF);
        tick();
        idle();
        for (int i = 0; i < 6; i++) set_rd(i, 3);
        #1;
        for (int i = 0; i < 6; i++) check($sformatf("beef_p%0d", i), rdd(i), 32'hBEEF);
        for (int r = 0; r < 8; r++) begin
            if (r != 3) begin
                set_rd(0, r);
                #1 check($sformatf("other_r%0d", r), rdd(0), 32'h0);
            end
        end

        // Write-port priority and forwarding
        wr(0, 5, 16'h1111); wr(1, 5, 16'h2222); set_rd(2, 5);
        #1;
        check("prio_fwd", rdd(2), 32'h2222);
        check("prio_nofwd", rdnb(2), 32'h0);
        tick();
        idle();
        #1;
        check("prio_stored", rdd(2), 32'h2222);
        check("prio_stored_nb", rdnb(2), 32'h2222);

        // Alloc / reject / write-clear
        alloc(2); set_rd(0, 2);
        #1 check("alloc_ok_r2", 32'(alloc_ok), 32'h1);
        tick();
        idle();
        #1;
        check("busy_r2_set", 32'(busy_vec), 32'h04);
        check("rd_busy_r2", 32'(rd_busy[0]), 32'h1);
        alloc(2);
        #1 check("alloc_reject_r2", 32'(alloc_ok), 32'h0);
        tick();
        check("reject_no_change", 32'(busy_vec), 32'h04);
        idle();
        wr(0, 2, 16'h00AA);
        #1;
        check("wr_fwd_busy", 32'(rd_busy[0]), 32'h0);
        check("wr_nofwd_busy", 32'(rd_busy_nb[0]), 32'h1);
        tick();
        idle();
        #1;
        check("busy_r2_clear", 32'(busy_vec), 32'h00);
        check("r2_data", rdd(0), 32'h00AA);

        // Accepted alloc and write to the same register in one cycle
        alloc(4); wr(1, 4, 16'h0044); set_rd(1, 4);
        #1 check("alloc_wr_ok", 32'(alloc_ok), 32'h1);
        tick();
        idle();
        #1;
        check("alloc_wins_busy", 32'(busy_vec), 32'h10);
        check("alloc_wr_data", rdd(1), 32'h0044);

        // Hardwired zero register
        wr(0, 0, 16'hFFFF); alloc(0); set_rd(0, 0);
        #1;
        check("z_alloc_ok", 32'(alloc_ok_z), 32'h1);
        check("z_rd_fwd", rdz(0), 32'h0);
        check("z_rd_busy", 32'(rd_busy_z[0]), 32'h0);
        tick();
        idle();
        #1;
        check("z_busy_vec", 32'(busy_vec_z), 32'h10);
        check("z_r0_data", rdz(0), 32'h0);
        check("nz_r0_data", rdd(0), 32'hFFFF);
        check("nz_busy_vec", 32'(busy_vec), 32'h11);
        alloc(0);
        #1;
        check("z_realloc_ok", 32'(alloc_ok_z), 32'h1);
        check("nz_realloc_ok", 32'(alloc_ok), 32'h0);
        idle();

        // Fill r1..r7, mark some busy, then pulse reset between edges
        wr(0, 1, 16'h1001); wr(1, 2, 16'h1002); tick();
        wr(0, 3, 16'h1003); wr(1, 4, 16'h1004); tick();
        wr(0, 5, 16'h1005); wr(1, 6, 16'h1006); tick();
        idle(); wr(0, 7, 16'h1007); tick();
        idle(); alloc(1); tick();
        alloc(3); tick();
        idle();
        for (int i = 0; i < 6; i++) set_rd(i, i + 1);
        #1;
        for (int i = 0; i < 6; i++) check($sformatf("fill_r%0d", i + 1), rdd(i), 32'h1001 + 32'(i));
        check("fill_busy", 32'(busy_vec), 32'h0B);
        check("fill_busy_z", 32'(busy_vec_z), 32'h0A);
        rst_n = 1'b0;
        #1;
        check("pulse_busy", 32'(busy_vec), 32'h0);
        for (int i = 0; i < 6; i++) check($sformatf("pulse_r%0d", i + 1), rdd(i), 32'h0);
        wr(0, 7, 16'h7777); alloc(6);
        tick();
        idle();
        #1 rst_n = 1'b1;
        set_rd(0, 7);
        #1;
        check("pulse_drop_wr", rdd(0), 32'h0);
        check("pulse_drop_alloc", 32'(busy_vec), 32'h0);

        // First write after release takes effect on the first edge
        wr(1, 1, 16'h5A5A); alloc(2); set_rd(0, 1);
        tick();
        idle();
        #1;
        check("post_rst_wr", rdnb(0), 32'h5A5A);
        check("post_rst_alloc", 32'(busy_vec), 32'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
